seg_ex_rx: RTL and testbench
============================

# seg_ex_rx

Receive-side counterpart of the seven-segment 74HC595 display driver: monitors the three-wire serial link (data_ser, srclk, rclk), rebuilds each latched 16-bit word, decodes digit-select and segment code back to a 4-bit hex nibble, and reassembles the full 8-digit, 32-bit display value. It is used for on-board loopback self-check and for bench verification of the display path. The link pins are sampled in the sys_clk domain, so no second clock is needed.

## Interface
- No parameters.
- sys_clk  in  1  system clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- data_ser  in  1  serial data, MSB of each 16-bit word first.
- srclk  in  1  shift clock; a rising edge shifts in one bit.
- rclk  in  1  storage clock; a rising edge latches the word.
- word_out  out  16  last latched word, {digit_sel[7:0], seg[7:0]}.
- word_valid  out  1  1-cycle pulse when word_out updates.
- data_out  out  32  last complete frame; nibble k = digit k.
- data_valid  out  1  1-cycle pulse when data_out updates.
- len_err  out  1  1-cycle pulse: rclk edge seen with shift count ≠ 16.
- code_err  out  1  1-cycle pulse: digit_sel not one-hot-low, or seg code not in the table.
- seq_err  out  1  1-cycle pulse: a valid digit arrived out of order.

## Operation
- Input stage: data_ser, srclk and rclk each pass through a 2-flop synchronizer, then one extra delay flop for edge detection. Rise is detected when the synced value is 1 and the delayed value is 0. data_ser is sampled from the same synchronizer stage, so it stays aligned with srclk.
- Shift register: 16 bits. On an srclk rise, shift left and insert data_ser at bit 0.
- Bit counter: 5 bits, saturates at 17. It increments on each srclk rise and clears on each rclk rise.
- On an rclk rise:
  - If count = 16: latch the shift register into word_out and pulse word_valid.
  - Otherwise: pulse len_err, do not update word_out, and force the frame FSM to IDLE.
- Digit index = position of the single 0 bit in digit_sel (bit 0 → digit 0).
- Segment table (active-low, {dp,g,f,e,d,c,b,a}):
  - 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8
  - 8:80 9:90 A:88 b:83 C:C6 d:A1 E:86 F:8E
  - Any other code, or a digit_sel that is not one-hot-low, pulses code_err and forces the FSM to IDLE.
- Frame FSM (states IDLE, COLLECT; a 3-bit expect counter; a 32-bit assembly register). Evaluated one cycle after word_valid on a decoded word:
  - IDLE, digit 0: store nibble 0, set expect = 1, go to COLLECT. Any other digit: stay in IDLE, no error.
  - COLLECT, digit = expect < 7: store nibble, increment expect.
  - COLLECT, digit = expect = 7: store nibble 7, copy the assembly (including the new nibble) to data_out, pulse data_valid, go to IDLE.
  - COLLECT, digit ≠ expect: pulse seq_err. If the digit is 0, restart the frame (store nibble 0, expect = 1). Otherwise go to IDLE.
- Reset values: all outputs 0, shift register 0, counter 0, FSM in IDLE, synchronizers 0.

## Timing
- word_valid asserts 4 sys_clk cycles after the rclk pin edge: 2 sync flops, 1 edge flop, 1 output register.
- data_valid, code_err and seq_err assert 1 cycle after the word_valid that triggers them.
- len_err asserts in the same cycle that word_valid would have.
- srclk and rclk must each stay high ≥ 2 and low ≥ 2 sys_clk cycles. data_ser must be stable from 3 cycles before to 1 cycle after each srclk rising edge. Faster links are unsupported.
- Simultaneous srclk and rclk rise detected in one cycle:
  - The latch takes the pre-shift register value, and the length check uses the pre-shift count.
  - The shift still occurs, and the counter ends at 1.
- An rst_n assertion mid-word or mid-frame discards all partial state immediately. The first rclk after release with fewer than 16 shifts raises len_err.
- Outputs hold their values between pulses. No back-pressure; every pulse lasts exactly 1 cycle.

## Test plan
- Frame 32'h1234ABCD sent as digits 0..7 (first word 16'hFEA1, last 16'h7FF9) → 8 word_valid pulses; data_out = 32'h1234ABCD with one data_valid 1 cycle after the eighth word; no error pulses.
- Word 16'hFEC0 sent with 15 srclk edges, then rclk → len_err pulses once; word_out unchanged; FSM returns to IDLE.
- Digits 0,1,2, then word 16'hFE99 (digit 0, value 4), then digits 1..7 → seq_err on the 4th word; data_valid on the last word, with data_out nibble 0 = 4.
- Word 16'hFCC0 (two digits selected), then word 16'hFE12 (unknown seg code) → code_err on each; no data_valid.
- Stream of digits 3..7 from IDLE → no pulses other than word_valid; data_out stays 0.
- rst_n low for 1 cycle after 8 srclk edges, then 16 edges and rclk → word_valid only; word_out equals the 16 post-reset bits.

Source files
------------

// File: rtl/seg_ex_rx.sv
// Purpose : receive side of the 7-segment 74HC595 link; rebuilds 16-bit words and 8-digit 32-bit frames.
// Latency : word_valid/len_err 4 sys_clk after the rclk pin edge; data_valid/code_err/seq_err 1 cycle after word_valid.
// Backpressure: none; every output pulse lasts one cycle, and the values hold between pulses.
// Ports: sys_clk, rst_n (async, active low); data_ser/srclk/rclk link pins (asynchronous to sys_clk);
//        word_out/word_valid latched word; data_out/data_valid assembled frame;
//        len_err, code_err, seq_err single-cycle error pulses.
module seg_ex_rx (
   input  logic        sys_clk,
   input  logic        rst_n,
   input  logic        data_ser,
   input  logic        srclk,
   input  logic        rclk,
   output logic [15:0] word_out,
   output logic        word_valid,
   output logic [31:0] data_out,
   output logic        data_valid,
   output logic        len_err,
   output logic        code_err,
   output logic        seq_err
);

   typedef enum logic [0:0] {IDLE, COLLECT} state_t;

   // synchronizers, delay flops and registered edge detectors
   logic ds_s1, ds_s2, ds_d;
   logic sc_s1, sc_s2, sc_d;
   logic rc_s1, rc_s2, rc_d;
   logic sc_rise, rc_rise;

   logic [15:0] shift_reg;
   logic [4:0]  bit_cnt;
   logic        len_fail;

   state_t      state;
   logic [2:0]  expect_dig;
   logic [31:0] asm_reg;

   logic        sel_ok;
   logic        seg_ok;
   logic [2:0]  dig_idx;
   logic [3:0]  nib;
   logic [3:0]  zeros;

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         ds_s1   <= 1'b0;
         ds_s2   <= 1'b0;
         ds_d    <= 1'b0;
         sc_s1   <= 1'b0;
         sc_s2   <= 1'b0;
         sc_d    <= 1'b0;
         rc_s1   <= 1'b0;
         rc_s2   <= 1'b0;
         rc_d    <= 1'b0;
         sc_rise <= 1'b0;
         rc_rise <= 1'b0;
      end else begin
         ds_s1   <= data_ser;
         ds_s2   <= ds_s1;
         sc_s1   <= srclk;
         sc_s2   <= sc_s1;
         sc_d    <= sc_s2;
         rc_s1   <= rclk;
         rc_s2   <= rc_s1;
         rc_d    <= rc_s2;
         sc_rise <= sc_s2 & ~sc_d;
         rc_rise <= rc_s2 & ~rc_d;
         // data is delayed alongside the registered srclk edge so the shift sees the bit that was at the pin with the edge
         ds_d    <= ds_s2;
      end
   end

   assign len_fail = rc_rise && (bit_cnt != 5'd16);

   // shift register, bit counter and word latch; on a simultaneous srclk/rclk edge the latch and
   // length check use pre-shift values while the shifted bit becomes the first bit of the next word
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_reg  <= 16'h0000;
         bit_cnt    <= 5'd0;
         word_out   <= 16'h0000;
         word_valid <= 1'b0;
         len_err    <= 1'b0;
      end else begin
         word_valid <= 1'b0;
         len_err    <= 1'b0;
         if (rc_rise) begin
            if (bit_cnt == 5'd16) begin
               word_out   <= shift_reg;
               word_valid <= 1'b1;
            end else begin
               len_err    <= 1'b1;
            end
         end
         if (sc_rise)
            shift_reg <= {shift_reg[14:0], ds_d};
         if (rc_rise)
            bit_cnt <= sc_rise ? 5'd1 : 5'd0;
         else if (sc_rise && (bit_cnt != 5'd17))
            bit_cnt <= bit_cnt + 5'd1;
      end
   end

   // decode the latched word: digit_sel must have exactly one low bit
   always_comb begin
      zeros   = 4'd0;
      dig_idx = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (!word_out[8+i]) begin
            zeros   = zeros + 4'd1;
            dig_idx = 3'(i);
         end
      end
      sel_ok = (zeros == 4'd1);
   end

   always_comb begin
      seg_ok = 1'b1;
      nib    = 4'h0;
      case (word_out[7:0])
         8'hC0: nib = 4'h0;
         8'hF9: nib = 4'h1;
         8'hA4: nib = 4'h2;
         8'hB0: nib = 4'h3;
         8'h99: nib = 4'h4;
         8'h92: nib = 4'h5;
         8'h82: nib = 4'h6;
         8'hF8: nib = 4'h7;
         8'h80: nib = 4'h8;
         8'h90: nib = 4'h9;
         8'h88: nib = 4'hA;
         8'h83: nib = 4'hB;
         8'hC6: nib = 4'hC;
         8'hA1: nib = 4'hD;
         8'h86: nib = 4'hE;
         8'h8E: nib = 4'hF;
         default: seg_ok = 1'b0;
      endcase
   end

   // frame FSM, evaluated the cycle after word_valid on the decoded word_out
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         expect_dig <= 3'd0;
         asm_reg    <= 32'h0;
         data_out   <= 32'h0;
         data_valid <= 1'b0;
         code_err   <= 1'b0;
         seq_err    <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         code_err   <= 1'b0;
         seq_err    <= 1'b0;
         if (len_fail) begin
            state <= IDLE;
         end else if (word_valid) begin
            if (!sel_ok || !seg_ok) begin
               code_err <= 1'b1;
               state    <= IDLE;
            end else begin
               case (state)
                  IDLE: begin
                     if (dig_idx == 3'd0) begin
                        asm_reg[3:0] <= nib;
                        expect_dig   <= 3'd1;
                        state        <= COLLECT;
                     end
                  end
                  COLLECT: begin
                     if (dig_idx == expect_dig) begin
                        asm_reg[{dig_idx, 2'b00} +: 4] <= nib;
                        if (expect_dig == 3'd7) begin
                           data_out   <= {nib, asm_reg[27:0]};
                           data_valid <= 1'b1;
                           state      <= IDLE;
                        end else begin
                           expect_dig <= expect_dig + 3'd1;
                        end
                     end else begin
                        seq_err <= 1'b1;
                        if (dig_idx == 3'd0) begin
                           // digit 0 out of order starts a fresh frame
                           asm_reg[3:0] <= nib;
                           expect_dig   <= 3'd1;
                        end else begin
                           state <= IDLE;
                        end
                     end
                  end
                  default: state <= IDLE;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_seg_ex_rx.sv
// Purpose : self-checking bench for seg_ex_rx with a word/frame-level reference model.
// Latency : stimulus runs on sys_clk falling edges; outputs are sampled on falling edges.
// Backpressure: none on the DUT; the bench paces the serial link at 3 sys_clk per half-period.
module tb_seg_ex_rx;

   logic        sys_clk = 1'b0;
   logic        rst_n;
   logic        data_ser;
   logic        srclk;
   logic        rclk;
   logic [15:0] word_out;
   logic        word_valid;
   logic [31:0] data_out;
   logic        data_valid;
   logic        len_err;
   logic        code_err;
   logic        seq_err;

   seg_ex_rx dut (
      .sys_clk    (sys_clk),
      .rst_n      (rst_n),
      .data_ser   (data_ser),
      .srclk      (srclk),
      .rclk       (rclk),
      .word_out   (word_out),
      .word_valid (word_valid),
      .data_out   (data_out),
      .data_valid (data_valid),
      .len_err    (len_err),
      .code_err   (code_err),
      .seq_err    (seq_err)
   );

   always #5 sys_clk = ~sys_clk;

   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // pulse monitor: counts pulses and checks their cycle position
   int m_wv = 0, m_dv = 0, m_len = 0, m_code = 0, m_seq = 0, lat_bad = 0;
   int last_wv_cyc = -100;
   int rclk_cyc = -100;

   always @(negedge sys_clk) begin
      if (rst_n) begin
         if (word_valid) begin
            m_wv        <= m_wv + 1;
            last_wv_cyc <= cyc;
            if (cyc - rclk_cyc != 4) lat_bad <= lat_bad + 1;
         end
         if (len_err) begin
            m_len <= m_len + 1;
            if (cyc - rclk_cyc != 4) lat_bad <= lat_bad + 1;
         end
         if (data_valid) begin
            m_dv <= m_dv + 1;
            if (cyc != last_wv_cyc + 1) lat_bad <= lat_bad + 1;
         end
         if (code_err) begin
            m_code <= m_code + 1;
            if (cyc != last_wv_cyc + 1) lat_bad <= lat_bad + 1;
         end
         if (seq_err) begin
            m_seq <= m_seq + 1;
            if (cyc != last_wv_cyc + 1) lat_bad <= lat_bad + 1;
         end
      end
   end

   // reference model
   logic [7:0]  seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
   logic [15:0] m_sr = 16'h0;
   int          m_cnt = 0;
   logic [15:0] e_word = 16'h0;
   logic [31:0] e_data = 32'h0;
   int          e_wv = 0, e_dv = 0, e_len = 0, e_code = 0, e_seq = 0;
   int          e_next = -1;          // -1: no frame in progress, else next digit wanted
   logic [3:0]  e_nib [8];

   task automatic model_decode(input logic [15:0] w);
      int zeros = 0;
      int dig = -1;
      int val = -1;
      for (int i = 0; i < 8; i++) if (w[8+i] == 1'b0) begin zeros++; dig = i; end
      for (int v = 0; v < 16; v++) if (seg_tab[v] == w[7:0]) val = v;
      if (zeros != 1 || val < 0) begin
         e_code++;
         e_next = -1;
      end else if (e_next < 0) begin
         if (dig == 0) begin e_nib[0] = 4'(val); e_next = 1; end
      end else if (dig == e_next) begin
         e_nib[dig] = 4'(val);
         if (dig == 7) begin
            for (int k = 0; k < 8; k++) e_data[4*k +: 4] = e_nib[k];
            e_dv++;
            e_next = -1;
         end else begin
            e_next++;
         end
      end else begin
         e_seq++;
         if (dig == 0) begin e_nib[0] = 4'(val); e_next = 1; end
         else e_next = -1;
      end
   endtask

   task automatic model_rclk();
      if (m_cnt == 16) begin
         e_word = m_sr;
         e_wv++;
         model_decode(m_sr);
      end else begin
         e_len++;
         e_next = -1;
      end
      m_cnt = 0;
   endtask

   task automatic model_shift(input logic b);
      m_sr = {m_sr[14:0], b};
      if (m_cnt < 17) m_cnt++;
   endtask

   task automatic model_reset();
      m_sr = 16'h0; m_cnt = 0; e_word = 16'h0; e_data = 32'h0; e_next = -1;
      for (int k = 0; k < 8; k++) e_nib[k] = 4'h0;
   endtask

   // link drivers
   task automatic tick(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic shift_bit(input logic b);
      data_ser = b;
      tick(3);
      srclk = 1'b1;
      tick(3);
      srclk = 1'b0;
      model_shift(b);
   endtask

   task automatic pulse_rclk();
      tick(3);
      rclk = 1'b1;
      rclk_cyc = cyc;
      tick(3);
      rclk = 1'b0;
      tick(6);
      model_rclk();
   endtask

   // srclk and rclk rise together: latch uses pre-shift state, then the bit is shifted in
   task automatic shift_bit_with_rclk(input logic b);
      data_ser = b;
      tick(3);
      srclk = 1'b1;
      rclk  = 1'b1;
      rclk_cyc = cyc;
      tick(3);
      srclk = 1'b0;
      rclk  = 1'b0;
      tick(6);
      model_rclk();
      model_shift(b);
   endtask

   task automatic send_bits(input logic [15:0] w, input int nbits);
      for (int i = 0; i < nbits; i++) shift_bit(w[15 - (i % 16)]);
   endtask

   task automatic send_word(input logic [15:0] w, input int nbits);
      send_bits(w, nbits);
      pulse_rclk();
   endtask

   function automatic logic [15:0] mk_word(input int digit, input logic [3:0] val);
      logic [7:0] sel;
      sel = ~(8'h01 << digit);
      return {sel, seg_tab[val]};
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic check_all(input string tag);
      check({tag, ".word_out"}, 32'(word_out), 32'(e_word));
      check({tag, ".data_out"}, data_out, e_data);
      check({tag, ".n_word_valid"}, 32'(m_wv), 32'(e_wv));
      check({tag, ".n_data_valid"}, 32'(m_dv), 32'(e_dv));
      check({tag, ".n_len_err"}, 32'(m_len), 32'(e_len));
      check({tag, ".n_code_err"}, 32'(m_code), 32'(e_code));
      check({tag, ".n_seq_err"}, 32'(m_seq), 32'(e_seq));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] v;
      logic [15:0] w;
      int          r;
      int          nb;

      rst_n = 1'b0; data_ser = 1'b0; srclk = 1'b0; rclk = 1'b0;
      model_reset();
      tick(4);
      check("rst.word_out", 32'(word_out), 32'h0);
      check("rst.word_valid", 32'(word_valid), 32'h0);
      check("rst.data_out", data_out, 32'h0);
      check("rst.data_valid", 32'(data_valid), 32'h0);
      check("rst.len_err", 32'(len_err), 32'h0);
      check("rst.code_err", 32'(code_err), 32'h0);
      check("rst.seq_err", 32'(seq_err), 32'h0);
      rst_n = 1'b1;
      tick(3);

      // digits 3..7 with no frame in progress: only word_valid pulses
      for (int k = 3; k < 8; k++) send_word(mk_word(k, 4'(k + 5)), 16);
      check_all("idle_stream");
      check("idle_stream.data_out_zero", data_out, 32'h0);

      // full frame 1234ABCD
      v = 32'h1234ABCD;
      for (int k = 0; k < 8; k++) send_word(mk_word(k, v[4*k +: 4]), 16);
      check_all("frame");
      check("frame.data_out_const", data_out, 32'h1234ABCD);

      // short word: len_err, word_out unchanged
      send_word(16'hFEC0, 15);
      check_all("short_word");
      check("short_word.word_out_kept", 32'(word_out), 32'h7FF9);

      // sequence restart on digit 0 mid-frame
      v = 32'h89ABCDEF;
      for (int k = 0; k < 3; k++) send_word(mk_word(k, v[4*k +: 4]), 16);
      send_word(16'hFE99, 16);
      for (int k = 1; k < 8; k++) send_word(mk_word(k, v[4*k +: 4]), 16);
      check_all("restart");
      check("restart.data_out_const", data_out, 32'h89ABCDE4);

      // bad digit_sel then bad segment code
      send_word(16'hFCC0, 16);
      send_word(16'hFE12, 16);
      check_all("code_err");

      // simultaneous srclk/rclk edge: latch pre-shift word, new word starts with the coincident bit
      w = mk_word(5, 4'h6);
      send_bits(16'hFDF9, 16);
      shift_bit_with_rclk(w[15]);
      for (int i = 14; i >= 0; i--) shift_bit(w[i]);
      pulse_rclk();
      check_all("simul_edge");
      check("simul_edge.word_out_const", 32'(word_out), {16'h0, w});

      // reset mid-word discards partial shifts
      send_bits(16'hA5A5, 8);
      tick(6);
      do_reset();
      tick(3);
      check("mid_reset.word_out_zero", 32'(word_out), 32'h0);
      pulse_rclk();
      check_all("mid_reset_short");
      send_bits(16'h3C3C, 8);
      tick(6);
      do_reset();
      tick(3);
      send_word(16'hBFC6, 16);
      check_all("mid_reset_full");
      check("mid_reset_full.word_out_const", 32'(word_out), 32'h0000BFC6);

      // randomized frames with occasional corrupted, misordered or mis-sized words
      for (int f = 0; f < 20; f++) begin
         v = $urandom;
         for (int k = 0; k < 8; k++) begin
            r  = $urandom_range(0, 11);
            nb = ($urandom_range(0, 24) == 0) ? $urandom_range(14, 17) : 16;
            if (r == 0)      w = 16'($urandom);
            else if (r == 1) w = mk_word($urandom_range(0, 7), 4'($urandom_range(0, 15)));
            else             w = mk_word(k, v[4*k +: 4]);
            send_word(w, nb);
         end
         check_all("random");
      end

      check("pulse_latency_violations", 32'(lat_bad), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
